// File: rtl/seq_add_sub_pkg.sv
// seq_add_sub_pkg: shared state encoding and mode constants for the digit-serial add/sub unit
package seq_add_sub_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/digit_add_slice.sv
// digit_add_slice: combinational ripple of DIGIT full adders, exposing the carry into its top bit
module digit_add_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);
    logic [DIGIT:0] w_c;
    assign w_c[0] = cin;
    for (genvar g = 0; g < DIGIT; g++) begin : g_fa
        assign sum[g]    = a[g] ^ b[g] ^ w_c[g];
        assign w_c[g+1]  = (a[g] & b[g]) | (w_c[g] & (a[g] ^ b[g]));
    end
    assign cout     = w_c[DIGIT];
    assign c_msb_in = w_c[DIGIT-1];
endmodule

// File: rtl/seq_add_sub_unit.sv
// seq_add_sub_unit: digit-serial two's-complement adder/subtracter with valid/ready handshakes
module seq_add_sub_unit
    import seq_add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             v
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [DIGIT-1:0] w_ds;
    logic             w_co, w_cm, w_last;
    assign w_last    = (r_cnt == CW'(N - 1));
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    // operands shift right so the current digit is always in the low bits
    digit_add_slice #(.DIGIT(DIGIT)) u_slice (
        .a        (r_a[DIGIT-1:0]),
        .b        (r_b[DIGIT-1:0]),
        .cin      (r_carry),
        .sum      (w_ds),
        .cout     (w_co),
        .c_msb_in (w_cm)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = in_valid  ? ST_CALC : ST_IDLE;
            ST_CALC: w_state_nxt = w_last    ? ST_DONE : ST_CALC;
            ST_DONE: w_state_nxt = out_ready ? ST_IDLE : ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            v       <= 1'b0;
        end else if (r_state == ST_IDLE && in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{s == MODE_SUB}};
            r_carry <= (s == MODE_SUB);
            r_cnt   <= '0;
        end else if (r_state == ST_CALC) begin
            sum[r_cnt*DIGIT +: DIGIT] <= w_ds;
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_co;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                cout <= w_co;
                v    <= w_co ^ w_cm;
            end
        end
    end
endmodule
